shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq_pkg.sv | 14 +
 rtl/shift_seq_step.sv | 37 +++
 rtl/shift_seq.sv | 88 ++++++++
 tb/tb_shift_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the sequential shifter: operation codes and FSM states.
package shift_seq_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_seq_step.sv
// Combinational one-bit shift stage. Sign replication for op 10 exists only
// when SHIFT_SEQ_SRA_EN is defined; otherwise op 10 and 11 behave as SRL.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic [1:0]   op,
    output logic [W-1:0] result
);

    logic fill;
    logic left;

`ifdef SHIFT_SEQ_SRA_EN
    assign fill = (op == OP_SRA) & value[W-1];
`else
    assign fill = 1'b0;
`endif

    assign left = (op == OP_SLL);

    // Each result bit picks its neighbour; the edge bits take the fill value.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign result[gi] = left ? 1'b0 : value[gi+1];
            end else if (gi == W - 1) begin : g_msb
                assign result[gi] = left ? value[gi-1] : fill;
            end else begin : g_mid
                assign result[gi] = left ? value[gi-1] : value[gi+1];
            end
        end
    endgenerate

endmodule

// File: rtl/shift_seq.sv
// Sequential barrel-shift replacement: one bit per clock through shift_step.
// Arithmetic right shift is built only with SHIFT_SEQ_SRA_EN defined.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int W  = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [W-1:0]  A,
    input  logic [SW-1:0] shift,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  res
);

    state_t        state_reg, state_next;
    logic [W-1:0]  res_reg, res_next;
    logic [SW-1:0] cnt_reg, cnt_next;
    logic [1:0]    op_reg, op_next;
    logic [W-1:0]  step_out;

    shift_step #(.W(W)) u_step (
        .value  (res_reg),
        .op     (op_reg),
        .result (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_reg <= '0;
            cnt_reg <= '0;
            op_reg  <= OP_SLL;
        end else begin
            res_reg <= res_next;
            cnt_reg <= cnt_next;
            op_reg  <= op_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        res_next   = res_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            // DONE accepts a start exactly like IDLE so operations can chain.
            ST_IDLE, ST_DONE: begin
                done = (state_reg == ST_DONE);
                if (start) begin
                    res_next   = A;
                    cnt_next   = shift;
                    op_next    = op;
                    state_next = (shift == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                busy     = 1'b1;
                res_next = step_out;
                cnt_next = cnt_reg - SW'(1);
                if (cnt_reg == SW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign res = res_reg;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: each accepted start pushes its expected
// result and completion cycle; every done pulse pops and compares.
module tb_shift_seq;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  A = '0;
    logic [SW-1:0] shift = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  res;

    shift_seq #(.W(W), .SW(SW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .shift (shift),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
        int           sh;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    bit   saw_done = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input int sh);
        case (o)
            2'b00: return a << sh;
`ifdef SHIFT_SEQ_SRA_EN
            2'b10: return $unsigned($signed(a) >>> sh);
`endif
            default: return a >> sh;
        endcase
    endfunction

    task automatic sample();
        if (busy) busy_cnt++;
        if (busy && done) check("busy_done_excl", 64'(busy & done), 64'd0);
        if (done) begin
            saw_done = 1;
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn done cyc=%0d res=0x%08h exp=0x%08h busy_cycles=%0d", cyc, res, e.res, busy_cnt);
                check("res", 64'(res), 64'(e.res));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_cycles", 64'(busy_cnt), 64'(e.sh));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        sample();
    endtask

    // Called right after a negedge, so start is sampled on the next rising edge.
    task automatic drive(input logic [1:0] o, input logic [W-1:0] a, input int sh);
        exp_t e;
        start = 1'b1;
        op    = o;
        A     = a;
        shift = SW'(sh);
        e.res = model(o, a, sh);
        e.cyc = cyc + 1 + sh;
        e.sh  = sh;
        sb.push_back(e);
        busy_cnt = 0;
        tick();
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        A     = $urandom;
        shift = SW'($urandom_range(0, W - 1));
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            check(tag, 64'd0, 64'd1);
            sb.delete();
        end
    endtask

    initial begin
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        // Start presented on the first edge after reset release.
        drive(2'b01, 32'h8000_0000, 4);
        wait_done("wait_srl4");

        drive(2'b00, 32'h0000_0001, 0);
        wait_done("wait_sll0");
        tick();
        tick();
        check("res_hold", 64'(res), 64'h1);

        drive(2'b10, 32'hF000_0000, 31);
        wait_done("wait_sra31");

        // Start during SHIFT must be ignored.
        drive(2'b01, 32'h8000_0000, 4);
        tick();
        start = 1'b1;
        op    = 2'b00;
        A     = 32'h0000_FFFF;
        shift = '0;
        tick();
        start = 1'b0;
        wait_done("wait_ignored");

        // Back-to-back: new start in the DONE cycle.
        drive(2'b01, 32'h1234_5678, 3);
        saw_done = 0;
        for (int i = 0; i < 40 && !saw_done; i++) tick();
        if (!saw_done) check("wait_b2b_first", 64'd0, 64'd1);
        drive(2'b00, 32'h0000_0003, 2);
        wait_done("wait_b2b_second");

        // Asynchronous reset mid-operation.
        drive(2'b00, 32'h0000_0001, 8);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_res", 64'(res), 64'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        drive(2'b00, 32'h0000_0001, 8);
        wait_done("wait_after_abort");

        for (int n = 0; n < 16; n++) begin
            drive(2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, W - 1)));
            wait_done("wait_random");
            if (n % 3 == 0) tick();
        end

        for (int i = 0; i < 5; i++) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
